// File: rtl/mem_port_arbiter.sv
// Shares one single-ported SRAM between the fetch (im) and data (dm) ports.
// Data wins by default; a saturating wait counter bounds fetch starvation.
module mem_port_arbiter #(
    parameter int AW       = 15,
    parameter int RD_LAT   = 1,
    parameter int MAX_WAIT = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [3:0]    dm_be,
    input  logic [31:0]   dm_addr,
    input  logic [31:0]   dm_wdata,
    output logic          dm_gnt,
    output logic          dm_rvalid,
    input  logic          im_req,
    input  logic [31:0]   im_addr,
    output logic          im_gnt,
    output logic          im_rvalid,
    output logic [31:0]   rdata,
    output logic          sram_ce,
    output logic [3:0]    sram_we,
    output logic [AW-1:0] sram_addr,
    output logic [31:0]   sram_wdata,
    input  logic [31:0]   sram_rdata
);
    localparam int WW = $clog2(MAX_WAIT + 1);

    logic [WW-1:0]     r_wait_cnt;
    logic [RD_LAT-1:0] r_tag_valid;
    logic [RD_LAT-1:0] r_tag_owner;

    logic w_im_forced;
    logic w_dm_gnt;
    logic w_im_gnt;
    logic w_ce;
    logic w_dm_store;
    logic w_unused;

    // Fetch takes the slot only once it has been denied MAX_WAIT times in a row.
    assign w_im_forced = im_req & (r_wait_cnt == WW'(MAX_WAIT));
    assign w_dm_gnt    = ~reset & dm_req & ~w_im_forced;
    assign w_im_gnt    = ~reset & im_req & ~w_dm_gnt;
    assign w_ce        = w_dm_gnt | w_im_gnt;
    assign w_dm_store  = w_dm_gnt & dm_we;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wait_cnt <= '0;
        end else if (~im_req | w_im_gnt) begin
            r_wait_cnt <= '0;
        end else if (r_wait_cnt != WW'(MAX_WAIT)) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    // Tag pipeline mirrors the SRAM read latency; owner 1 = dm, 0 = im.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tag_valid <= '0;
            r_tag_owner <= '0;
        end else begin
            r_tag_valid[0] <= w_ce & ~w_dm_store;
            r_tag_owner[0] <= w_dm_gnt;
            for (int i = 1; i < RD_LAT; i++) begin
                r_tag_valid[i] <= r_tag_valid[i-1];
                r_tag_owner[i] <= r_tag_owner[i-1];
            end
        end
    end

    assign dm_gnt     = w_dm_gnt;
    assign im_gnt     = w_im_gnt;
    assign sram_ce    = w_ce;
    assign sram_we    = w_dm_store ? dm_be : 4'b0000;
    assign sram_addr  = w_dm_gnt ? dm_addr[AW+1:2] : im_addr[AW+1:2];
    assign sram_wdata = dm_wdata;
    assign rdata      = sram_rdata;

    assign dm_rvalid  = ~reset & r_tag_valid[RD_LAT-1] &  r_tag_owner[RD_LAT-1];
    assign im_rvalid  = ~reset & r_tag_valid[RD_LAT-1] & ~r_tag_owner[RD_LAT-1];

    // High address bits alias and byte-offset bits are meaningless for word access.
    assign w_unused = ^{dm_addr[31:AW+2], dm_addr[1:0], im_addr[31:AW+2], im_addr[1:0]};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: two instances (RD_LAT 1 and 2) share
// stimulus; a model predicts grants and a queue scoreboard predicts read returns.
module tb_mem_port_arbiter;
    localparam int AW = 15;

    typedef struct {
        int          due;
        logic        owner;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        preload;
    logic        dm_req, dm_we, im_req;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr, dm_wdata, im_addr;

    logic          dm_gnt1, dm_rvalid1, im_gnt1, im_rvalid1, sram_ce1;
    logic [31:0]   rdata1, sram_wdata1, sram_rdata1;
    logic [3:0]    sram_we1;
    logic [AW-1:0] sram_addr1;
    logic          dm_gnt2, dm_rvalid2, im_gnt2, im_rvalid2, sram_ce2;
    logic [31:0]   rdata2, sram_wdata2, sram_rdata2, r2_stage;
    logic [3:0]    sram_we2;
    logic [AW-1:0] sram_addr2;

    logic [31:0] mem1    [0:(1<<AW)-1];
    logic [31:0] mem2    [0:(1<<AW)-1];
    logic [31:0] ref_mem [0:(1<<AW)-1];

    exp_t q1[$];
    exp_t q2[$];

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;
    int m_wait = 0;

    logic        last_dm_gnt, last_im_gnt;
    logic        last_dm_rv1, last_im_rv1, last_dm_rv2, last_im_rv2;
    logic [31:0] last_addr, last_we, last_wait, last_rdata1;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(AW), .RD_LAT(1), .MAX_WAIT(3)) dut1 (
        .clk(clk), .reset(reset),
        .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt1), .dm_rvalid(dm_rvalid1),
        .im_req(im_req), .im_addr(im_addr), .im_gnt(im_gnt1), .im_rvalid(im_rvalid1),
        .rdata(rdata1), .sram_ce(sram_ce1), .sram_we(sram_we1), .sram_addr(sram_addr1),
        .sram_wdata(sram_wdata1), .sram_rdata(sram_rdata1)
    );

    mem_port_arbiter #(.AW(AW), .RD_LAT(2), .MAX_WAIT(3)) dut2 (
        .clk(clk), .reset(reset),
        .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt2), .dm_rvalid(dm_rvalid2),
        .im_req(im_req), .im_addr(im_addr), .im_gnt(im_gnt2), .im_rvalid(im_rvalid2),
        .rdata(rdata2), .sram_ce(sram_ce2), .sram_we(sram_we2), .sram_addr(sram_addr2),
        .sram_wdata(sram_wdata2), .sram_rdata(sram_rdata2)
    );

    function automatic logic [31:0] init_word(int i);
        if (i == 2) return 32'h1122_3344;
        if (i == 4) return 32'hDEAD_BEEF;
        return 32'hA500_0000 + 32'(i);
    endfunction

    // SRAM models: one-cycle and two-cycle read latency
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) mem1[i] = init_word(i);
        end else if (sram_ce1) begin
            for (int b = 0; b < 4; b++)
                if (sram_we1[b]) mem1[sram_addr1][8*b +: 8] = sram_wdata1[8*b +: 8];
            if (sram_we1 == 4'b0000) sram_rdata1 <= mem1[sram_addr1];
        end
    end

    always @(posedge clk) begin
        sram_rdata2 <= r2_stage;
        if (preload) begin
            for (int i = 0; i < 64; i++) mem2[i] = init_word(i);
        end else if (sram_ce2) begin
            for (int b = 0; b < 4; b++)
                if (sram_we2[b]) mem2[sram_addr2][8*b +: 8] = sram_wdata2[8*b +: 8];
            if (sram_we2 == 4'b0000) r2_stage <= mem2[sram_addr2];
        end
    end

    task automatic chk1(string tag, logic obs, logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, cyc_n);
        end
    endtask

    task automatic chk32(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc_n);
        end
    endtask

    // One clock cycle: sample at negedge, compare against model, advance model.
    task automatic cyc();
        logic          e_dm, e_im, e_rvd, e_rvi;
        logic [AW-1:0] e_addr;
        @(negedge clk);
        if (reset) begin
            e_dm = 1'b0;
            e_im = 1'b0;
            q1.delete();
            q2.delete();
        end else begin
            e_dm = dm_req && !(im_req && m_wait == 3);
            e_im = im_req && !e_dm;
        end
        e_addr = e_dm ? dm_addr[AW+1:2] : im_addr[AW+1:2];

        chk1("dm_gnt1", dm_gnt1, e_dm);
        chk1("im_gnt1", im_gnt1, e_im);
        chk1("dm_gnt2", dm_gnt2, e_dm);
        chk1("im_gnt2", im_gnt2, e_im);
        chk1("sram_ce", sram_ce1, e_dm | e_im);
        chk32("sram_we", 32'(sram_we1), (e_dm && dm_we) ? 32'(dm_be) : 32'h0);
        if (e_dm | e_im) chk32("sram_addr", 32'(sram_addr1), 32'(e_addr));
        chk32("wait_cnt1", 32'(dut1.r_wait_cnt), 32'(m_wait));
        chk32("wait_cnt2", 32'(dut2.r_wait_cnt), 32'(m_wait));

        e_rvd = 1'b0; e_rvi = 1'b0;
        if (q1.size() > 0 && q1[0].due == cyc_n) begin
            e_rvd = q1[0].owner;
            e_rvi = !q1[0].owner;
            chk32("rdata1", rdata1, q1[0].data);
            void'(q1.pop_front());
        end
        chk1("dm_rvalid1", dm_rvalid1, e_rvd);
        chk1("im_rvalid1", im_rvalid1, e_rvi);

        e_rvd = 1'b0; e_rvi = 1'b0;
        if (q2.size() > 0 && q2[0].due == cyc_n) begin
            e_rvd = q2[0].owner;
            e_rvi = !q2[0].owner;
            chk32("rdata2", rdata2, q2[0].data);
            void'(q2.pop_front());
        end
        chk1("dm_rvalid2", dm_rvalid2, e_rvd);
        chk1("im_rvalid2", im_rvalid2, e_rvi);

        last_dm_gnt = dm_gnt1;     last_im_gnt = im_gnt1;
        last_addr   = 32'(sram_addr1);
        last_we     = 32'(sram_we1);
        last_wait   = 32'(dut1.r_wait_cnt);
        last_dm_rv1 = dm_rvalid1;  last_im_rv1 = im_rvalid1;  last_rdata1 = rdata1;
        last_dm_rv2 = dm_rvalid2;  last_im_rv2 = im_rvalid2;

        if (e_dm && dm_we) begin
            for (int b = 0; b < 4; b++)
                if (dm_be[b]) ref_mem[e_addr][8*b +: 8] = dm_wdata[8*b +: 8];
        end else if (e_dm | e_im) begin
            q1.push_back('{cyc_n + 1, e_dm, ref_mem[e_addr]});
            q2.push_back('{cyc_n + 2, e_dm, ref_mem[e_addr]});
        end

        if (reset || !im_req || e_im) m_wait = 0;
        else if (m_wait < 3)          m_wait = m_wait + 1;

        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    initial begin
        reset = 1'b1; preload = 1'b1;
        dm_req = 1'b0; dm_we = 1'b0; dm_be = 4'h0; dm_addr = '0; dm_wdata = '0;
        im_req = 1'b0; im_addr = '0;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        @(posedge clk); #1;
        preload = 1'b0;
        cyc(); cyc();
        reset = 1'b0;

        // fetch alone
        im_req = 1'b1; im_addr = 32'h0000_0010;
        cyc();
        chk1("t1_im_gnt", last_im_gnt, 1'b1);
        chk32("t1_addr", last_addr, 32'd4);
        im_req = 1'b0;
        cyc();
        chk1("t1_im_rvalid", last_im_rv1, 1'b1);
        chk32("t1_rdata", last_rdata1, 32'hDEAD_BEEF);
        chk1("t1_dm_rvalid", last_dm_rv1, 1'b0);

        // contention: dm,dm,dm,im repeating
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h14;
        im_req = 1'b1; im_addr = 32'h18;
        for (int k = 0; k < 8; k++) begin
            cyc();
            chk1("t2_im_gnt", last_im_gnt, (k % 4) == 3);
            chk32("t2_wait", last_wait, 32'(k % 4));
        end
        dm_req = 1'b0; im_req = 1'b0;
        cyc(); cyc();

        // partial store then readback
        dm_req = 1'b1; dm_we = 1'b1; dm_be = 4'b0010; dm_addr = 32'h8; dm_wdata = 32'h0000_AB00;
        cyc();
        chk32("t3_we", last_we, 32'h2);
        dm_req = 1'b0; dm_we = 1'b0; dm_be = 4'h0;
        cyc();
        chk32("t3_word2_l1", mem1[2], 32'h1122_AB44);
        chk32("t3_word2_l2", mem2[2], 32'h1122_AB44);
        chk1("t3_no_rvalid", last_dm_rv1, 1'b0);
        dm_req = 1'b1; dm_addr = 32'h8;
        cyc();
        dm_req = 1'b0;
        cyc();
        chk32("t3_readback", last_rdata1, 32'h1122_AB44);
        cyc();

        // interleave load / fetch / store, checked on the RD_LAT=2 instance
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h1C;
        cyc();
        dm_req = 1'b0; im_req = 1'b1; im_addr = 32'h20;
        cyc();
        im_req = 1'b0; dm_req = 1'b1; dm_we = 1'b1; dm_be = 4'hF;
        dm_addr = 32'h24; dm_wdata = 32'hCAFE_F00D;
        cyc();
        chk1("t4_dm_rv_n2", last_dm_rv2, 1'b1);
        dm_req = 1'b0; dm_we = 1'b0; dm_be = 4'h0;
        cyc();
        chk1("t4_im_rv_n3", last_im_rv2, 1'b1);
        chk1("t4_dm_rv_n3", last_dm_rv2, 1'b0);
        cyc();
        chk1("t4_im_rv_n4", last_im_rv2, 1'b0);
        chk1("t4_dm_rv_n4", last_dm_rv2, 1'b0);

        // store with no byte enables
        dm_req = 1'b1; dm_we = 1'b1; dm_be = 4'h0; dm_addr = 32'h28; dm_wdata = 32'hFFFF_FFFF;
        cyc();
        chk1("tbe0_gnt", last_dm_gnt, 1'b1);
        chk32("tbe0_we", last_we, 32'h0);
        dm_we = 1'b0;
        cyc();
        dm_req = 1'b0;
        cyc();
        chk32("tbe0_readback", last_rdata1, init_word(10));

        // address aliasing
        dm_req = 1'b1; dm_addr = 32'h0002_0004;
        cyc();
        chk32("t6_alias_addr", last_addr, 32'd1);
        dm_req = 1'b0;
        cyc();
        chk32("t6_alias_data", last_rdata1, init_word(1));
        cyc();

        // reset one cycle after a fetch grant
        im_req = 1'b1; im_addr = 32'h30;
        cyc();
        im_req = 1'b1; dm_req = 1'b1; dm_addr = 32'h4;
        reset = 1'b1;
        #1;
        chk1("t5_dm_gnt", dm_gnt2, 1'b0);
        chk1("t5_im_gnt", im_gnt2, 1'b0);
        chk1("t5_ce", sram_ce2, 1'b0);
        chk32("t5_we", 32'(sram_we2), 32'h0);
        chk1("t5_im_rv1", im_rvalid1, 1'b0);
        chk1("t5_im_rv2", im_rvalid2, 1'b0);
        chk1("t5_dm_rv2", dm_rvalid2, 1'b0);
        cyc(); cyc();
        reset = 1'b0; im_req = 1'b0;
        cyc();
        chk1("t5_first_gnt", last_dm_gnt, 1'b1);
        chk1("t5_no_im_rv", last_im_rv2, 1'b0);
        chk32("t5_wait", last_wait, 32'h0);
        dm_req = 1'b0;
        cyc(); cyc(); cyc();
        chk1("t5_tail_im_rv", last_im_rv2, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
